// File: rtl/ppu_pkg.sv
// Shared constants, dot-phase encodings and scroll-position helpers for the
// PPU background fetch engine.
package ppu_pkg;

  // Default nametable window base and attribute-table offset within a nametable.
  localparam logic [13:0] NT_BASE_DEFAULT = 14'h2000;
  localparam logic [9:0]  AT_OFS_DEFAULT  = 10'h3C0;

  // Dot phases within one 8-dot tile slot.
  // Even phases present an address and odd phases capture the returned byte.
  localparam logic [2:0] PH_NT     = 3'd0;  // nametable address
  localparam logic [2:0] PH_NT_RD  = 3'd1;  // nametable byte capture
  localparam logic [2:0] PH_AT     = 3'd2;  // attribute address
  localparam logic [2:0] PH_AT_RD  = 3'd3;  // attribute byte capture
  localparam logic [2:0] PH_PLO    = 3'd4;  // pattern low-plane address
  localparam logic [2:0] PH_PLO_RD = 3'd5;  // pattern low-plane capture
  localparam logic [2:0] PH_PHI    = 3'd6;  // pattern high-plane address
  localparam logic [2:0] PH_PHI_RD = 3'd7;  // pattern high-plane capture + reload

  // Scroll position: nametable select, coarse Y, coarse X and fine Y.
  typedef struct packed {
    logic [1:0] nt;
    logic [4:0] cy;
    logic [4:0] cx;
    logic [2:0] fy;
  } scroll_pos_t;

  // Step one tile to the right; wrapping off column 31 flips to the horizontally adjacent nametable.
  function automatic scroll_pos_t inc_coarse_x(input scroll_pos_t p);
    scroll_pos_t r;
    r = p;
    if (p.cx == 5'd31) begin
      r.cx    = 5'd0;
      r.nt[0] = ~p.nt[0];
    end else begin
      r.cx = p.cx + 5'd1;
    end
    return r;
  endfunction

  // Step one scanline down. Row 29 is the last visible row and flips the vertical
  // nametable; rows 30/31 are the attribute area, and wrapping from 31 does not flip.
  function automatic scroll_pos_t inc_y(input scroll_pos_t p);
    scroll_pos_t r;
    r = p;
    if (p.fy != 3'd7) begin
      r.fy = p.fy + 3'd1;
    end else begin
      r.fy = 3'd0;
      if (p.cy == 5'd29) begin
        r.cy    = 5'd0;
        r.nt[1] = ~p.nt[1];
      end else if (p.cy == 5'd31) begin
        r.cy = 5'd0;
      end else begin
        r.cy = p.cy + 5'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ppu_bg_shifter.sv
// Background pixel shifters: two pattern planes plus two attribute planes,
// 16 bits each. Every enabled dot shifts all four left by one. On a reload dot,
// the fresh tile is written into the low byte after that dot's shift.
// A fine-X tap selects the bit presented for the current dot.
module ppu_bg_shifter
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       load_en,
  input  logic [7:0] pat_lo,
  input  logic [7:0] pat_hi,
  input  logic [1:0] at_bits,
  input  logic [2:0] fine_x,
  output logic [1:0] pix_sel,
  output logic [1:0] pal_sel
);

  logic [7:0] load_byte [4];
  logic [3:0] tap;
  logic [3:0] sel_bit;

  // Plane order: 0 = pattern low, 1 = pattern high, 2 = attribute low, 3 = attribute high.
  // Each attribute bit is replicated across the whole tile.
  assign load_byte[0] = pat_lo;
  assign load_byte[1] = pat_hi;
  assign load_byte[2] = {8{at_bits[0]}};
  assign load_byte[3] = {8{at_bits[1]}};

  // Fine X = 0 shows the MSB; larger values look further ahead into the stream.
  assign tap = 4'd15 - {1'b0, fine_x};

  for (genvar gi = 0; gi < 4; gi++) begin : g_plane
    logic [15:0] sr_reg;

    // Shift each dot; on reload, replace the low byte after shifting.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr_reg <= '0;
      end else if (shift_en) begin
        if (load_en) begin
          sr_reg <= {sr_reg[14:7], load_byte[gi]};
        end else begin
          sr_reg <= {sr_reg[14:0], 1'b0};
        end
      end
    end

    assign sel_bit[gi] = sr_reg[tap];
  end

  assign pix_sel = {sel_bit[1], sel_bit[0]};
  assign pal_sel = {sel_bit[3], sel_bit[2]};

endmodule

// File: rtl/ppu_bg_fetcher.sv
// PPU background fetch engine. It runs an 8-dot per-tile sequence over the PPU
// bus: nametable, attribute, then two pattern planes. It feeds the pixel
// shifters and keeps the loopy-style scroll position (coarse X/Y, fine Y,
// nametable) up to date.
module ppu_bg_fetcher #(
  parameter logic [13:0] NT_BASE = ppu_pkg::NT_BASE_DEFAULT,
  parameter logic [9:0]  AT_OFS  = ppu_pkg::AT_OFS_DEFAULT
) (
  input  logic        MasterClk,
  input  logic        Reset_n,
  input  logic        PixelEn,
  input  logic        FetchEn,
  input  logic        LineStart,
  input  logic        LineEnd,
  input  logic        FrameStart,
  input  logic [4:0]  ScrollCoarseX,
  input  logic [4:0]  ScrollCoarseY,
  input  logic [2:0]  ScrollFineY,
  input  logic [1:0]  ScrollNT,
  input  logic [2:0]  FineX,
  input  logic        BgPatternSel,
  output logic [13:0] PPU_Addr,
  output logic        PPU_RD,
  input  logic [7:0]  PPU_DataIn,
  output logic [1:0]  BgPixel,
  output logic [1:0]  BgPalette
);
  import ppu_pkg::*;

  logic [2:0]  phase_reg, phase_next;
  scroll_pos_t pos_reg, pos_next;
  logic [13:0] addr_reg, addr_next;
  logic        rd_reg, rd_next;
  logic [7:0]  nt_byte_reg, nt_byte_next;
  logic [1:0]  at_bits_reg, at_bits_next;
  logic [7:0]  pat_lo_reg, pat_lo_next;
  logic [1:0]  pix_reg, pix_next;
  logic [1:0]  pal_reg, pal_next;

  logic        fetch_step;
  logic [13:0] nt_addr, at_addr, pat_addr;
  logic [1:0]  at_quad;
  logic [1:0]  at_pick;
  logic [1:0]  pix_sel, pal_sel;

  assign fetch_step = PixelEn & FetchEn;

  // Bus addresses derived from the current scroll position and the captured tile index.
  assign nt_addr  = NT_BASE | {2'b00, pos_reg.nt, 10'd0} | {4'd0, pos_reg.cy, pos_reg.cx};
  assign at_addr  = NT_BASE | {2'b00, pos_reg.nt, 10'd0} | {4'd0, AT_OFS}
                  | {8'd0, pos_reg.cy[4:2], pos_reg.cx[4:2]};
  assign pat_addr = {1'b0, BgPatternSel, nt_byte_reg, 1'b0, pos_reg.fy};

  // Each attribute byte covers a 4x4-tile area; this quadrant picks the
  // 2-bit field for the current 2x2 group.
  assign at_quad = {pos_reg.cy[1], pos_reg.cx[1]};
  assign at_pick = {PPU_DataIn[{at_quad, 1'b1}], PPU_DataIn[{at_quad, 1'b0}]};

  // Next-state logic for the sequencer, bus address, data latches and scroll position.
  always_comb begin
    phase_next   = phase_reg;
    pos_next     = pos_reg;
    addr_next    = addr_reg;
    rd_next      = rd_reg;
    nt_byte_next = nt_byte_reg;
    at_bits_next = at_bits_reg;
    pat_lo_next  = pat_lo_reg;
    pix_next     = pix_reg;
    pal_next     = pal_reg;

    if (PixelEn) begin
      if (FetchEn) begin
        phase_next = phase_reg + 3'd1;
        case (phase_reg)
          PH_NT:     addr_next    = nt_addr;
          PH_NT_RD:  nt_byte_next = PPU_DataIn;
          PH_AT:     addr_next    = at_addr;
          PH_AT_RD:  at_bits_next = at_pick;
          PH_PLO:    addr_next    = pat_addr;
          PH_PLO_RD: pat_lo_next  = PPU_DataIn;
          PH_PHI:    addr_next    = pat_addr | 14'h0008;
          PH_PHI_RD: pos_next     = inc_coarse_x(pos_reg);
          default:   ;
        endcase
        pix_next = pix_sel;
        pal_next = pal_sel;
      end else begin
        // Idle: abandon any partial tile and blank the output.
        phase_next = PH_NT;
        pix_next   = 2'b00;
        pal_next   = 2'b00;
      end

      // Vertical scroll: a frame reload takes precedence over the line increment.
      if (FrameStart) begin
        pos_next.cy    = ScrollCoarseY;
        pos_next.fy    = ScrollFineY;
        pos_next.nt[1] = ScrollNT[1];
      end else if (LineEnd) begin
        pos_next = inc_y(pos_next);
      end

      // Horizontal reload wins over the same-dot coarse-X increment and restarts the slot.
      if (LineStart) begin
        pos_next.cx    = ScrollCoarseX;
        pos_next.nt[0] = ScrollNT[0];
        phase_next     = PH_NT;
      end

      // The read strobe tracks the phase being entered: high for 0-6 and low for the capture-only phase 7.
      rd_next = FetchEn && (phase_next != PH_PHI_RD);
    end
  end

  // State registers.
  always_ff @(posedge MasterClk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_reg   <= PH_NT;
      pos_reg     <= '0;
      addr_reg    <= '0;
      rd_reg      <= 1'b0;
      nt_byte_reg <= '0;
      at_bits_reg <= '0;
      pat_lo_reg  <= '0;
      pix_reg     <= '0;
      pal_reg     <= '0;
    end else begin
      phase_reg   <= phase_next;
      pos_reg     <= pos_next;
      addr_reg    <= addr_next;
      rd_reg      <= rd_next;
      nt_byte_reg <= nt_byte_next;
      at_bits_reg <= at_bits_next;
      pat_lo_reg  <= pat_lo_next;
      pix_reg     <= pix_next;
      pal_reg     <= pal_next;
    end
  end

  // On the high-plane capture dot, the byte arriving on the bus goes straight into the shifters.
  ppu_bg_shifter u_shifter (
    .clk      (MasterClk),
    .rst_n    (Reset_n),
    .shift_en (fetch_step),
    .load_en  (phase_reg == PH_PHI_RD),
    .pat_lo   (pat_lo_reg),
    .pat_hi   (PPU_DataIn),
    .at_bits  (at_bits_reg),
    .fine_x   (FineX),
    .pix_sel  (pix_sel),
    .pal_sel  (pal_sel)
  );

  assign PPU_Addr  = addr_reg;
  assign PPU_RD    = rd_reg;
  assign BgPixel   = pix_reg;
  assign BgPalette = pal_reg;

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// Self-checking bench for ppu_bg_fetcher. A byte-array PPU memory answers the
// bus. A tile-level reference model predicts the bus addresses, the read strobe
// and the pixel/palette stream produced by each slot.
module tb_ppu_bg_fetcher;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        PixelEn = 1'b0;
  logic        FetchEn = 1'b0;
  logic        LineStart = 1'b0;
  logic        LineEnd = 1'b0;
  logic        FrameStart = 1'b0;
  logic [4:0]  ScrollCoarseX = '0;
  logic [4:0]  ScrollCoarseY = '0;
  logic [2:0]  ScrollFineY = '0;
  logic [1:0]  ScrollNT = '0;
  logic [2:0]  FineX = '0;
  logic        BgPatternSel = 1'b0;
  logic [13:0] PPU_Addr;
  logic        PPU_RD;
  logic [7:0]  PPU_DataIn;
  logic [1:0]  BgPixel;
  logic [1:0]  BgPalette;

  logic [7:0]  mem [16384];

  int checks = 0;
  int failures = 0;

  // Reference scroll position.
  int m_cx = 0, m_cy = 0, m_fy = 0, m_nt = 0;

  always #5 clk = ~clk;

  assign PPU_DataIn = mem[PPU_Addr];

  ppu_bg_fetcher dut (
    .MasterClk     (clk),
    .Reset_n       (Reset_n),
    .PixelEn       (PixelEn),
    .FetchEn       (FetchEn),
    .LineStart     (LineStart),
    .LineEnd       (LineEnd),
    .FrameStart    (FrameStart),
    .ScrollCoarseX (ScrollCoarseX),
    .ScrollCoarseY (ScrollCoarseY),
    .ScrollFineY   (ScrollFineY),
    .ScrollNT      (ScrollNT),
    .FineX         (FineX),
    .BgPatternSel  (BgPatternSel),
    .PPU_Addr      (PPU_Addr),
    .PPU_RD        (PPU_RD),
    .PPU_DataIn    (PPU_DataIn),
    .BgPixel       (BgPixel),
    .BgPalette     (BgPalette)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One enabled dot, then sample 1 ns after the edge.
  task automatic dot(input logic fe, input logic ls, input logic le, input logic fs);
    FetchEn    = fe;
    LineStart  = ls;
    LineEnd    = le;
    FrameStart = fs;
    PixelEn    = 1'b1;
    @(posedge clk);
    #1;
    PixelEn    = 1'b0;
    LineStart  = 1'b0;
    LineEnd    = 1'b0;
    FrameStart = 1'b0;
  endtask

  task automatic model_line_end();
    if (m_fy < 7) begin
      m_fy = m_fy + 1;
    end else begin
      m_fy = 0;
      if (m_cy == 29) begin
        m_cy = 0;
        m_nt = m_nt ^ 2;
      end else if (m_cy == 31) begin
        m_cy = 0;
      end else begin
        m_cy = m_cy + 1;
      end
    end
  endtask

  // One dot with fetching disabled, carrying scroll control strobes.
  task automatic ctrl(input logic ls, input logic le, input logic fs);
    dot(1'b0, ls, le, fs);
    if (fs) begin
      m_cy = int'(ScrollCoarseY);
      m_fy = int'(ScrollFineY);
      m_nt = (m_nt & 1) | (int'(ScrollNT[1]) * 2);
    end else if (le) begin
      model_line_end();
    end
    if (ls) begin
      m_cx = int'(ScrollCoarseX);
      m_nt = (m_nt & 2) | int'(ScrollNT[0]);
    end
    chk("idle_rd", 16'(PPU_RD), 16'(0));
    chk("idle_pix", 16'(BgPixel), 16'(0));
    chk("idle_pal", 16'(BgPalette), 16'(0));
  endtask

  // Run nslots tile slots from phase 0. If abort_at >= 0, drop FetchEn at that
  // phase of the last slot. Pixel of stream position k (tile k/8, pixel k%8)
  // appears on BgPixel after enabled dot k+16-FineX of this run.
  task automatic run_slots(input int nslots, input int abort_at);
    logic [1:0]  pix_q [$];
    logic [1:0]  pal_q [$];
    logic [13:0] a [4];
    logic [13:0] exp_addr;
    logic [7:0]  plo, phi;
    int n, idx, nb, ab, quad, pal, lo;
    exp_addr = '0;
    n = 0;
    for (int t = 0; t < nslots; t++) begin
      a[0] = 14'(32'h2000 + m_nt * 1024 + m_cy * 32 + m_cx);
      nb   = int'(mem[a[0]]);
      a[1] = 14'(32'h23C0 + m_nt * 1024 + (m_cy / 4) * 8 + (m_cx / 4));
      ab   = int'(mem[a[1]]);
      quad = ((m_cy / 2) % 2) * 2 + ((m_cx / 2) % 2);
      pal  = (ab >> (2 * quad)) % 4;
      lo   = int'(BgPatternSel) * 4096 + nb * 16 + m_fy;
      a[2] = 14'(lo);
      a[3] = 14'(lo + 8);
      plo  = mem[a[2]];
      phi  = mem[a[3]];
      for (int p = 0; p < 8; p++) begin
        if (t == nslots - 1 && p == abort_at) begin
          dot(1'b0, 1'b0, 1'b0, 1'b0);
          chk("abort_rd", 16'(PPU_RD), 16'(0));
          chk("abort_pix", 16'(BgPixel), 16'(0));
          chk("abort_pal", 16'(BgPalette), 16'(0));
          chk("abort_addr_hold", 16'(PPU_Addr), 16'(exp_addr));
          return;
        end
        dot(1'b1, 1'b0, 1'b0, 1'b0);
        if (p % 2 == 0) exp_addr = a[p / 2];
        chk("addr", 16'(PPU_Addr), 16'(exp_addr));
        chk("rd", 16'(PPU_RD), 16'(p != 6));
        idx = n - 16 + int'(FineX);
        if (idx >= 0 && idx < pix_q.size()) begin
          chk("pix", 16'(BgPixel), 16'(pix_q[idx]));
          chk("pal", 16'(BgPalette), 16'(pal_q[idx]));
        end
        n++;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
          chk("addr_hold", 16'(PPU_Addr), 16'(exp_addr));
        end
      end
      for (int i = 0; i < 8; i++) begin
        pix_q.push_back({phi[7 - i], plo[7 - i]});
        pal_q.push_back(2'(pal));
      end
      if (m_cx == 31) begin
        m_cx = 0;
        m_nt = m_nt ^ 1;
      end else begin
        m_cx = m_cx + 1;
      end
    end
    dot(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stop_rd", 16'(PPU_RD), 16'(0));
    chk("stop_pix", 16'(BgPixel), 16'(0));
    chk("stop_pal", 16'(BgPalette), 16'(0));
    chk("stop_addr_hold", 16'(PPU_Addr), 16'(exp_addr));
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);

    // Reset values
    Reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 16'(PPU_Addr), 16'(0));
    chk("rst_rd", 16'(PPU_RD), 16'(0));
    chk("rst_pix", 16'(BgPixel), 16'(0));
    chk("rst_pal", 16'(BgPalette), 16'(0));
    Reset_n = 1'b1;

    // Case 1: basic tile with fine Y = 2 (addresses 2000/23C0/0122/012A)
    mem[14'h2000] = 8'h12;
    mem[14'h0122] = 8'hF0;
    mem[14'h012A] = 8'h0F;
    ScrollFineY = 3'd2;
    ctrl(1'b1, 1'b0, 1'b1);
    run_slots(4, -1);

    // Case 2: same tile row with fine X = 3
    FineX = 3'd3;
    ctrl(1'b1, 1'b0, 1'b0);
    run_slots(4, -1);
    FineX = 3'd0;

    // Case 3: coarse-X wrap into the next nametable
    ScrollCoarseX = 5'd31;
    ScrollNT = 2'd0;
    ctrl(1'b1, 1'b0, 1'b0);
    run_slots(3, -1);

    // Case 4: vertical wrap at rows 29 and 31, frame reload beats line end
    ScrollCoarseX = 5'd0;
    ScrollCoarseY = 5'd29;
    ScrollFineY = 3'd7;
    ctrl(1'b0, 1'b0, 1'b1);
    ctrl(1'b0, 1'b1, 1'b0);
    ctrl(1'b1, 1'b0, 1'b0);
    run_slots(1, -1);
    ScrollCoarseY = 5'd31;
    ctrl(1'b0, 1'b0, 1'b1);
    ctrl(1'b0, 1'b1, 1'b0);
    ctrl(1'b1, 1'b0, 1'b0);
    run_slots(1, -1);
    ScrollCoarseY = 5'd5;
    ctrl(1'b1, 1'b1, 1'b1);
    ctrl(1'b0, 1'b1, 1'b0);
    run_slots(2, -1);

    // Case 5: attribute quadrant select (E4 -> 3 at cx=2,cy=2; 0 at cx=0,cy=0)
    mem[14'h23C0] = 8'hE4;
    ScrollCoarseX = 5'd2;
    ScrollCoarseY = 5'd2;
    ScrollFineY = 3'd0;
    ScrollNT = 2'd0;
    ctrl(1'b1, 1'b0, 1'b1);
    run_slots(3, -1);
    ScrollCoarseX = 5'd0;
    ScrollCoarseY = 5'd0;
    ctrl(1'b1, 1'b0, 1'b1);
    run_slots(3, -1);

    // Randomized scroll, fine X, pattern half and control strobes
    for (int k = 0; k < 6; k++) begin
      ScrollCoarseX = 5'($urandom);
      ScrollCoarseY = 5'($urandom);
      ScrollFineY = 3'($urandom);
      ScrollNT = 2'($urandom);
      FineX = 3'($urandom);
      BgPatternSel = 1'($urandom);
      ctrl(1'($urandom), 1'($urandom), 1'($urandom));
      run_slots(3 + int'($urandom_range(0, 2)), -1);
    end

    // Case 6: FetchEn dropped at phase 5 (no cx increment), then resume
    FineX = 3'd0;
    BgPatternSel = 1'b0;
    ScrollCoarseX = 5'd4;
    ctrl(1'b1, 1'b0, 1'b0);
    run_slots(2, 5);
    run_slots(3, -1);

    // Reset asserted mid-slot: strobe and outputs drop without a clock edge
    for (int i = 0; i < 3; i++) dot(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    Reset_n = 1'b0;
    FetchEn = 1'b0;
    #1;
    chk("midrst_rd", 16'(PPU_RD), 16'(0));
    chk("midrst_addr", 16'(PPU_Addr), 16'(0));
    chk("midrst_pix", 16'(BgPixel), 16'(0));
    chk("midrst_pal", 16'(BgPalette), 16'(0));
    m_cx = 0;
    m_cy = 0;
    m_fy = 0;
    m_nt = 0;
    repeat (2) @(posedge clk);
    #4;
    Reset_n = 1'b1;
    run_slots(3, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
